stripe_tx_scheduler: RTL and testbench

- Transmit-side sequencer that sits directly upstream of byte_striper. Each cycle it decides what the striper carries: framed TLP dwords, a framed DLLP, a SKP ordered set, or logical idle.
- Arbitrates the TLP and DLLP sources only at packet boundaries. Injects SKP ordered sets on a programmable interval.
- Drives one registered dword and per-byte D/K flags per cycle for a x4 link.

---
 rtl/stripe_tx_scheduler_pkg.sv | 28 ++
 rtl/stripe_tx_scheduler_if.sv | 44 ++++
 rtl/stripe_tx_scheduler_skp_timer.sv | 64 ++++++
 rtl/stripe_tx_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_stripe_tx_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/stripe_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// striper_pkg
// Shared definitions for the stripe_tx_scheduler slice: 8b/10b symbol
// constants for framing and ordered sets, the scheduler state encoding and
// the pending-SKP counter type.
// -----------------------------------------------------------------------------
package striper_pkg;

  // Framing / ordered-set symbols (K codes unless noted)
  localparam logic [7:0] K_COM  = 8'hBC;
  localparam logic [7:0] K_SKP  = 8'h1C;
  localparam logic [7:0] K_SDP  = 8'h5C;
  localparam logic [7:0] K_END  = 8'hFD;
  localparam logic [7:0] D_IDLE = 8'h00;  // data symbol for logical idle

  // Default saturation limit; skp_cnt_t is sized to hold it.
  localparam int MAX_PENDING_SKP_DEF = 3;

  typedef logic [$clog2(MAX_PENDING_SKP_DEF + 1) - 1:0] skp_cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TLP   = 2'd1,
    DLLP2 = 2'd2,
    SKP   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/stripe_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// stripe_tx_scheduler_if
// Bundles the TLP source, DLLP source and striper-facing signals of the
// scheduler.
//
// Handshake: a TLP dword (or a whole DLLP) moves in a cycle where its valid
// and the matching ready are both high at the clock edge. Valid must not
// depend on ready; ready may depend on valid (the DLLP ready does). The
// striper side has no back-pressure: o_mu_data/o_d_k/o_underrun are a new
// registered symbol set every cycle.
//
//   i_tlp_valid/data/k/sop/eop, o_tlp_ready : pre-framed TLP dword stream
//   i_dllp_valid/data, o_dllp_ready         : 6-byte DLLP, byte 0 in [7:0]
//   o_mu_data, o_d_k                        : dword and per-lane K flags
//   o_underrun                              : pulse on mid-TLP valid gap
//
// master: source/consumer side (testbench). slave: the scheduler.
// -----------------------------------------------------------------------------
interface stripe_tx_scheduler_if;
  logic        i_tlp_valid;
  logic [31:0] i_tlp_data;
  logic [3:0]  i_tlp_k;
  logic        i_tlp_sop;
  logic        i_tlp_eop;
  logic        o_tlp_ready;
  logic        i_dllp_valid;
  logic [47:0] i_dllp_data;
  logic        o_dllp_ready;
  logic [31:0] o_mu_data;
  logic [3:0]  o_d_k;
  logic        o_underrun;

  modport master (
    output i_tlp_valid, i_tlp_data, i_tlp_k, i_tlp_sop, i_tlp_eop,
    output i_dllp_valid, i_dllp_data,
    input  o_tlp_ready, o_dllp_ready, o_mu_data, o_d_k, o_underrun
  );

  modport slave (
    input  i_tlp_valid, i_tlp_data, i_tlp_k, i_tlp_sop, i_tlp_eop,
    input  i_dllp_valid, i_dllp_data,
    output o_tlp_ready, o_dllp_ready, o_mu_data, o_d_k, o_underrun
  );
endinterface

// File: rtl/stripe_tx_scheduler_skp_timer.sv
// -----------------------------------------------------------------------------
// skp_interval_timer
// Free-running SKP interval counter plus saturating pending-SKP counter.
// Every SKP_INTERVAL cycles one SKP ordered set becomes owed; the scheduler
// pays one off by pulsing i_skp_start.
//
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_skp_start    : scheduler is starting an SKP OS this cycle
//   o_pending_nz   : at least one SKP OS is owed
// -----------------------------------------------------------------------------
module skp_interval_timer
  import striper_pkg::*;
#(
  parameter int SKP_INTERVAL    = 1180,
  parameter int MAX_PENDING_SKP = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_skp_start,
  output logic o_pending_nz
);

  localparam int              TW         = $clog2(SKP_INTERVAL);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SKP_INTERVAL - 1);
  localparam skp_cnt_t        PEND_MAX   = skp_cnt_t'(MAX_PENDING_SKP);

  generate
    if (SKP_INTERVAL < 8) begin : g_bad_interval
      $error("skp_interval_timer: SKP_INTERVAL must be at least 8");
    end
    if (MAX_PENDING_SKP < 1 || MAX_PENDING_SKP > (2 ** $bits(skp_cnt_t)) - 1) begin : g_bad_pend
      $error("skp_interval_timer: MAX_PENDING_SKP does not fit skp_cnt_t");
    end
  endgenerate

  logic [TW-1:0] timer_q, timer_d;
  skp_cnt_t      pending_q, pending_d;
  logic          expire;

  always_comb begin
    expire    = (timer_q == TIMER_LAST);
    timer_d   = expire ? '0 : timer_q + 1'b1;
    pending_d = pending_q;
    // Simultaneous expiry and start cancel out, even at saturation.
    if (expire && !i_skp_start) begin
      if (pending_q != PEND_MAX) pending_d = pending_q + 1'b1;
    end else if (!expire && i_skp_start) begin
      if (pending_q != '0) pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign o_pending_nz = (pending_q != '0);

endmodule

// File: rtl/stripe_tx_scheduler.sv
// -----------------------------------------------------------------------------
// stripe_tx_scheduler
// Per-cycle sequencer ahead of byte_striper on a x4 link. Chooses between a
// framed TLP dword, a two-dword framed DLLP, a four-dword SKP ordered set or
// logical idle. Sources are arbitrated only at packet boundaries; owed SKP
// ordered sets win, then DLLPs, then TLPs. All striper outputs are
// registered (one cycle after the decision/transfer).
//
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : TLP/DLLP sources and striper outputs
//   o_dbg_state    : current scheduler state
//   o_stat_*       : 16-bit wrapping event counters, only present when
//                    STRIPE_SCHED_STATS_EN is defined
// Optional feature macro: STRIPE_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module stripe_tx_scheduler
  import striper_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int SKP_INTERVAL    = 1180,
  parameter int MAX_PENDING_SKP = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  stripe_tx_scheduler_if.slave bus,
  output sched_state_e         o_dbg_state
`ifdef STRIPE_SCHED_STATS_EN
  ,
  output logic [15:0]          o_stat_tlp,
  output logic [15:0]          o_stat_dllp,
  output logic [15:0]          o_stat_skp,
  output logic [15:0]          o_stat_underrun
`endif
);

  generate
    if (NUM_LANES != 4) begin : g_bad_lanes
      $error("stripe_tx_scheduler: only NUM_LANES=4 is supported");
    end
  endgenerate

  sched_state_e state_q, state_d;
  logic [1:0]   skp_cnt_q, skp_cnt_d;      // SKP symbol index, 1..3 in SKP
  logic [23:0]  dllp_hi_q, dllp_hi_d;      // DLLP bytes 5..3 for DLLP2
  logic [31:0]  mu_data_q, mu_data_d;
  logic [3:0]   d_k_q, d_k_d;
  logic         underrun_q, underrun_d;
  logic         pending_nz, skp_start;
  logic         tlp_ready, dllp_ready;

  skp_interval_timer #(
    .SKP_INTERVAL   (SKP_INTERVAL),
    .MAX_PENDING_SKP(MAX_PENDING_SKP)
  ) u_skp_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_skp_start (skp_start),
    .o_pending_nz(pending_nz)
  );

  // State register (also holds the registered datapath)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      skp_cnt_q  <= '0;
      dllp_hi_q  <= '0;
      mu_data_q  <= '0;
      d_k_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skp_cnt_q  <= skp_cnt_d;
      dllp_hi_q  <= dllp_hi_d;
      mu_data_q  <= mu_data_d;
      d_k_q      <= d_k_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    skp_cnt_d = skp_cnt_q;
    case (state_q)
      IDLE: begin
        if (pending_nz) begin
          state_d   = SKP;
          skp_cnt_d = 2'd1;
        end else if (bus.i_dllp_valid) begin
          state_d = DLLP2;
        end else if (bus.i_tlp_valid && bus.i_tlp_sop && !bus.i_tlp_eop) begin
          state_d = TLP;
        end
      end
      TLP: begin
        if (bus.i_tlp_valid && bus.i_tlp_eop) state_d = IDLE;
      end
      DLLP2: state_d = IDLE;
      SKP: begin
        if (skp_cnt_q == 2'd3) begin
          state_d   = IDLE;
          skp_cnt_d = '0;
        end else begin
          skp_cnt_d = skp_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: readies, SKP start and the next registered symbols
  always_comb begin
    tlp_ready  = 1'b0;
    dllp_ready = 1'b0;
    skp_start  = 1'b0;
    mu_data_d  = {4{D_IDLE}};
    d_k_d      = 4'b0000;
    underrun_d = 1'b0;
    dllp_hi_d  = dllp_hi_q;
    case (state_q)
      IDLE: begin
        if (pending_nz) begin
          skp_start = 1'b1;
          mu_data_d = {4{K_COM}};
          d_k_d     = 4'b1111;
        end else if (bus.i_dllp_valid) begin
          dllp_ready = 1'b1;
          mu_data_d  = {bus.i_dllp_data[23:0], K_SDP};
          d_k_d      = 4'b0001;
          dllp_hi_d  = bus.i_dllp_data[47:24];
        end else begin
          tlp_ready = 1'b1;
          // A dword without sop here is a stray: accepted and discarded.
          if (bus.i_tlp_valid && bus.i_tlp_sop) begin
            mu_data_d = bus.i_tlp_data;
            d_k_d     = bus.i_tlp_k;
          end
        end
      end
      TLP: begin
        tlp_ready = 1'b1;
        if (bus.i_tlp_valid) begin
          mu_data_d = bus.i_tlp_data;
          d_k_d     = bus.i_tlp_k;
        end else begin
          underrun_d = 1'b1;
        end
      end
      DLLP2: begin
        mu_data_d = {K_END, dllp_hi_q};
        d_k_d     = 4'b1000;
      end
      SKP: begin
        mu_data_d = {4{K_SKP}};
        d_k_d     = 4'b1111;
      end
      default: ;
    endcase
    // Nothing is accepted while reset is held.
    if (!i_rst_n) begin
      tlp_ready  = 1'b0;
      dllp_ready = 1'b0;
      skp_start  = 1'b0;
    end
  end

  assign bus.o_tlp_ready  = tlp_ready;
  assign bus.o_dllp_ready = dllp_ready;
  assign bus.o_mu_data    = mu_data_q;
  assign bus.o_d_k        = d_k_q;
  assign bus.o_underrun   = underrun_q;
  assign o_dbg_state      = state_q;

`ifdef STRIPE_SCHED_STATS_EN
  logic [15:0] stat_tlp_q, stat_dllp_q, stat_skp_q, stat_underrun_q;
  logic        tlp_pkt_end;

  // Packet end: accepted eop that belongs to a packet (stray dwords in IDLE
  // without sop are discarded and not counted).
  assign tlp_pkt_end = tlp_ready && bus.i_tlp_valid && bus.i_tlp_eop &&
                       ((state_q == TLP) || bus.i_tlp_sop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stat_tlp_q      <= '0;
      stat_dllp_q     <= '0;
      stat_skp_q      <= '0;
      stat_underrun_q <= '0;
    end else begin
      if (tlp_pkt_end) stat_tlp_q      <= stat_tlp_q + 16'd1;
      if (dllp_ready)  stat_dllp_q     <= stat_dllp_q + 16'd1;
      if (skp_start)   stat_skp_q      <= stat_skp_q + 16'd1;
      if (underrun_d)  stat_underrun_q <= stat_underrun_q + 16'd1;
    end
  end

  assign o_stat_tlp      = stat_tlp_q;
  assign o_stat_dllp     = stat_dllp_q;
  assign o_stat_skp      = stat_skp_q;
  assign o_stat_underrun = stat_underrun_q;
`endif

endmodule

// File: tb/tb_stripe_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_stripe_tx_scheduler
// Directed bench for stripe_tx_scheduler with SKP_INTERVAL=16. Each cycle
// record holds the inputs, the expected combinational readies and the
// expected registered outputs produced by that cycle's clock edge.
// -----------------------------------------------------------------------------
module tb_stripe_tx_scheduler;
  import striper_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stripe_tx_scheduler_if bus_if();
  sched_state_e dbg_state;
`ifdef STRIPE_SCHED_STATS_EN
  logic [15:0] stat_tlp, stat_dllp, stat_skp, stat_underrun;
`endif

  stripe_tx_scheduler #(
    .NUM_LANES      (4),
    .SKP_INTERVAL   (16),
    .MAX_PENDING_SKP(3)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus_if),
    .o_dbg_state(dbg_state)
`ifdef STRIPE_SCHED_STATS_EN
    ,
    .o_stat_tlp     (stat_tlp),
    .o_stat_dllp    (stat_dllp),
    .o_stat_skp     (stat_skp),
    .o_stat_underrun(stat_underrun)
`endif
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic        rst_n;
    logic        tv;
    logic [31:0] td;
    logic [3:0]  tk;
    logic        sop;
    logic        eop;
    logic        dv;
    logic [47:0] dd;
    logic        exp_tr;
    logic        exp_dr;
    logic [31:0] exp_data;
    logic [3:0]  exp_k;
    logic        exp_ur;
  } vec_t;

  function automatic vec_t mk(logic r, logic tv, logic [31:0] td, logic [3:0] tk,
                              logic sop, logic eop, logic dv, logic [47:0] dd,
                              logic etr, logic edr, logic [31:0] ed, logic [3:0] ek,
                              logic eur);
    vec_t v;
    v.rst_n = r;   v.tv = tv;   v.td = td;   v.tk = tk;   v.sop = sop;
    v.eop = eop;   v.dv = dv;   v.dd = dd;
    v.exp_tr = etr; v.exp_dr = edr; v.exp_data = ed; v.exp_k = ek; v.exp_ur = eur;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Apply one cycle: drive inputs, check readies before the edge, then check
  // the registered outputs just after it.
  task automatic run_cycle(input vec_t v, input string tag);
    logic [31:0] exp_data;
    rst_n               = v.rst_n;
    bus_if.i_tlp_valid  = v.tv;
    bus_if.i_tlp_data   = v.td;
    bus_if.i_tlp_k      = v.tk;
    bus_if.i_tlp_sop    = v.sop;
    bus_if.i_tlp_eop    = v.eop;
    bus_if.i_dllp_valid = v.dv;
    bus_if.i_dllp_data  = v.dd;
    exp_q.push_back(v.exp_data);
    #1;
    chk({tag, ".tlp_ready"},  64'(bus_if.o_tlp_ready),  64'(v.exp_tr));
    chk({tag, ".dllp_ready"}, 64'(bus_if.o_dllp_ready), 64'(v.exp_dr));
    @(posedge clk);
    #1;
    exp_data = exp_q.pop_front();
    chk({tag, ".mu_data"},  64'(bus_if.o_mu_data),  64'(exp_data));
    chk({tag, ".d_k"},      64'(bus_if.o_d_k),      64'(v.exp_k));
    chk({tag, ".underrun"}, 64'(bus_if.o_underrun), 64'(v.exp_ur));
  endtask

  task automatic idle_cycle(input logic r, input logic etr, input logic [31:0] ed,
                            input logic [3:0] ek, input string tag);
    run_cycle(mk(r, 0, '0, '0, 0, 0, 0, '0, etr, 0, ed, ek, 0), tag);
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 1'b0, 32'h0, 4'h0, $sformatf("%s.rst%0d", tag, i));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [47:0] DD_A = 48'h0605_0403_0201;
  localparam logic [47:0] DD_B = 48'h0A09_0807_0605;
  localparam logic [47:0] DD_C = 48'h0C0B_0A09_0807;
  localparam logic [47:0] DD_D = 48'h1615_1413_1211;
  localparam logic [47:0] DD_E = 48'h2625_2423_2221;

  vec_t tbl[$];

  initial begin
    // Table: reset with valids high, DLLP, TLP + late DLLP, stray dword,
    // single-dword TLP, SKP preempting both sources, then the backlog.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 32'hAABBCCDD, 4'h0, 1, 1, 1, 48'hFFEEDDCCBBAA, 0, 0, 32'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k1
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 1, DD_A, 0, 1, 32'h0302015C, 4'h1, 0)); // k2
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 1, DD_B, 0, 0, 32'hFD060504, 4'h8, 0)); // k3
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k4
    tbl.push_back(mk(1, 1, 32'hA1A2A3FB, 4'h1, 1, 0, 0, '0,   1, 0, 32'hA1A2A3FB, 4'h1, 0)); // k5
    tbl.push_back(mk(1, 1, 32'hB0B1B2B3, 4'h0, 0, 0, 1, DD_C, 1, 0, 32'hB0B1B2B3, 4'h0, 0)); // k6
    tbl.push_back(mk(1, 1, 32'hFDC0C1C2, 4'h8, 0, 1, 1, DD_C, 1, 0, 32'hFDC0C1C2, 4'h8, 0)); // k7
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 1, DD_C, 0, 1, 32'h0908075C, 4'h1, 0)); // k8
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   0, 0, 32'hFD0C0B0A, 4'h8, 0)); // k9
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k10
    tbl.push_back(mk(1, 1, 32'hDEADBEEF, 4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k11
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k12
    tbl.push_back(mk(1, 1, 32'h12345678, 4'h0, 1, 1, 0, '0,   1, 0, 32'h12345678, 4'h0, 0)); // k13
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k14
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k15
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k16
    tbl.push_back(mk(1, 1, 32'h77777777, 4'h0, 1, 1, 1, DD_D, 0, 0, 32'hBCBCBCBC, 4'hF, 0)); // k17
    for (int i = 0; i < 3; i++)                                                              // k18-20
      tbl.push_back(mk(1, 1, 32'h77777777, 4'h0, 1, 1, 1, DD_D, 0, 0, 32'h1C1C1C1C, 4'hF, 0));
    tbl.push_back(mk(1, 1, 32'h77777777, 4'h0, 1, 1, 1, DD_D, 0, 1, 32'h1312115C, 4'h1, 0)); // k21
    tbl.push_back(mk(1, 1, 32'h77777777, 4'h0, 1, 1, 0, '0,   0, 0, 32'hFD161514, 4'h8, 0)); // k22
    tbl.push_back(mk(1, 1, 32'h77777777, 4'h0, 1, 1, 0, '0,   1, 0, 32'h77777777, 4'h0, 0)); // k23
    tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0,   1, 0, 32'h0,        4'h0, 0)); // k24

    for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i], $sformatf("tbl[%0d]", i));

    // Periodic SKP with no traffic: COM at k=17,33 then three SKP dwords.
    do_reset("skp");
    for (int k = 1; k <= 40; k++) begin
      int ph;
      logic [31:0] ed;
      logic busy;
      ph   = (k - 17) % 16;
      busy = (k >= 17) && (ph <= 3);
      ed   = !busy ? 32'h0 : (ph == 0 ? 32'hBCBCBCBC : 32'h1C1C1C1C);
      idle_cycle(1'b1, !busy, ed, busy ? 4'hF : 4'h0, $sformatf("skp.k%0d", k));
    end

    // 10-dword TLP k10..19, timer expires at k16, DLLP waiting from k12:
    // TLP runs through, then SKP OS, then DLLP, then no SKP until k33.
    do_reset("pre");
    for (int k = 1; k <= 33; k++) begin
      vec_t v;
      logic in_tlp;
      in_tlp     = (k >= 10) && (k <= 19);
      v          = mk(1, in_tlp, 32'h50000000 + 32'(k), 4'h0, k == 10, k == 19,
                      (k >= 12) && (k <= 24), DD_E, 0, k == 24, 32'h0, 4'h0, 0);
      v.exp_tr   = (k <= 19) || ((k >= 26) && (k <= 32));
      if (in_tlp)                     v.exp_data = 32'h50000000 + 32'(k);
      else if (k == 20 || k == 33)    begin v.exp_data = 32'hBCBCBCBC; v.exp_k = 4'hF; end
      else if (k >= 21 && k <= 23)    begin v.exp_data = 32'h1C1C1C1C; v.exp_k = 4'hF; end
      else if (k == 24)               begin v.exp_data = 32'h2322215C; v.exp_k = 4'h1; end
      else if (k == 25)               begin v.exp_data = 32'hFD262524; v.exp_k = 4'h8; end
      run_cycle(v, $sformatf("pre.k%0d", k));
    end

    // Underrun: one-cycle valid gap inside a 4-dword TLP.
    do_reset("ur");
    idle_cycle(1'b1, 1'b1, 32'h0, 4'h0, "ur.k1");
    run_cycle(mk(1, 1, 32'h31313131, 4'h0, 1, 0, 0, '0, 1, 0, 32'h31313131, 4'h0, 0), "ur.k2");
    run_cycle(mk(1, 1, 32'h32323232, 4'h0, 0, 0, 0, '0, 1, 0, 32'h32323232, 4'h0, 0), "ur.k3");
    run_cycle(mk(1, 0, 32'h0,        4'h0, 0, 0, 0, '0, 1, 0, 32'h0,        4'h0, 1), "ur.k4");
    run_cycle(mk(1, 1, 32'h33333333, 4'h0, 1, 0, 0, '0, 1, 0, 32'h33333333, 4'h0, 0), "ur.k5");
    run_cycle(mk(1, 1, 32'h34343434, 4'h0, 0, 1, 0, '0, 1, 0, 32'h34343434, 4'h0, 0), "ur.k6");
    idle_cycle(1'b1, 1'b1, 32'h0, 4'h0, "ur.k7");
    idle_cycle(1'b1, 1'b1, 32'h0, 4'h0, "ur.k8");
`ifdef STRIPE_SCHED_STATS_EN
    chk("stat_tlp",      64'(stat_tlp),      64'd1);
    chk("stat_dllp",     64'(stat_dllp),     64'd0);
    chk("stat_skp",      64'(stat_skp),      64'd0);
    chk("stat_underrun", 64'(stat_underrun), 64'd1);
`endif

    // Reset mid-packet: abandon the TLP, next output is idle in IDLE.
    run_cycle(mk(1, 1, 32'h41414141, 4'h0, 1, 0, 0, '0, 1, 0, 32'h41414141, 4'h0, 0), "mr.sop");
    run_cycle(mk(0, 1, 32'h42424242, 4'h0, 0, 0, 0, '0, 0, 0, 32'h0,        4'h0, 0), "mr.rst");
    idle_cycle(1'b1, 1'b1, 32'h0, 4'h0, "mr.after");
    chk("mr.state", 64'(dbg_state), 64'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
